// File: rtl/syscall_print_queue.sv
// Print-syscall FIFO feeding a paced seven-segment display value.
// Ports: clk, rst (async low), en, wb_syscall, v0_data, a0_data in;
//   led_data, shown, fifo_count, empty, full, dropped, exited out.
module syscall_print_queue #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 50000000,
    parameter int PRINT_CODE  = 1,
    parameter int EXIT_CODE   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wb_syscall,
    input  logic [DATA_WIDTH-1:0]   v0_data,
    input  logic [DATA_WIDTH-1:0]   a0_data,
    output logic [DATA_WIDTH-1:0]   led_data,
    output logic                    shown,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    empty,
    output logic                    full,
    output logic                    dropped,
    output logic                    exited
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] PRINT_VAL = DATA_WIDTH'(PRINT_CODE);
    localparam logic [DATA_WIDTH-1:0] EXIT_VAL = DATA_WIDTH'(EXIT_CODE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [1:0]            r_state;
    logic [HW-1:0]         r_hold;
    logic [DATA_WIDTH-1:0] r_led;
    logic                  r_dropped;
    logic                  r_exited;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_exit_req;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));

    // Pop only from registered state, so a push into an empty queue
    // reaches the display one edge later, never the same edge.
    assign w_pop = !w_empty && (r_state != S_SHOW || r_hold == '0);

    assign w_push_req = en && wb_syscall && (v0_data == PRINT_VAL) && !r_exited;
    assign w_exit_req = en && wb_syscall && (v0_data == EXIT_VAL);

    // A full queue still takes a push when a pop frees a slot this edge.
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= a0_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_led   <= '0;
        end else if (w_pop) begin
            r_led   <= r_mem[r_rd_ptr];
            r_hold  <= HOLD_MAX;
            r_state <= S_SHOW;
        end else if (r_state == S_SHOW) begin
            if (r_hold != '0) begin
                r_hold <= r_hold - HW'(1);
            end else begin
                r_state <= S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dropped <= 1'b0;
            r_exited  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
            if (w_exit_req) begin
                r_exited <= 1'b1;
            end
        end
    end

    assign led_data   = r_led;
    assign shown      = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign dropped    = r_dropped;
    assign exited     = r_exited;

endmodule
